// File: rtl/fft256_share_sched.sv
// fft256_share_sched: round-robin time-sharing of a single FFT_256 core
// between a forward requester and an inverse requester, one frame at a time.
// INV frames use the conjugation trick: conj on input, conj + scale on output.
module fft256_share_sched #(
  parameter int unsigned N           = 256,
  parameter int unsigned SCALE_SHIFT = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_fwd,
  input  logic               req_inv,
  output logic               gnt_fwd,
  output logic               gnt_inv,
  input  logic               s_valid,
  input  logic signed [15:0] s_real,
  input  logic signed [15:0] s_img,
  output logic               core_in_valid,
  output logic signed [15:0] core_x_real,
  output logic signed [15:0] core_x_img,
  input  logic               core_out_valid,
  input  logic signed [15:0] core_y_real,
  input  logic signed [15:0] core_y_img,
  output logic               y_valid,
  output logic signed [15:0] y_real,
  output logic signed [15:0] y_img,
  output logic               y_is_inv,
  output logic               y_last,
  output logic               busy,
  output logic               err_gap,
  output logic               err_timeout
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            inv_q, inv_d;          // owner of the current frame
  logic            pref_inv_q, pref_inv_d; // round-robin pointer
  logic            err_gap_q, err_gap_d;
  logic            err_tmo_q, err_tmo_d;
  logic            y_valid_q, y_is_inv_q, y_last_q;
  logic signed [15:0] y_real_q, y_img_q;

  logic            take;      // capture a core result beat this cycle
  logic            take_last; // captured beat is sample N-1
  logic            pick_inv;
  logic            in_load;

  logic signed [15:0] x_img_conj;
  logic signed [15:0] y_real_d, y_img_d;
  logic signed [16:0] img_neg;

  // Next-state, counters, arbitration and error pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    inv_d      = inv_q;
    pref_inv_d = pref_inv_q;
    err_gap_d  = 1'b0;
    err_tmo_d  = 1'b0;
    take       = 1'b0;
    take_last  = 1'b0;
    pick_inv   = req_inv && (!req_fwd || pref_inv_q);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (req_fwd || req_inv) begin
          inv_d      = pick_inv;
          pref_inv_d = !pick_inv;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q != '0) begin
          err_gap_d = 1'b1;
          cnt_d     = '0;
          tmo_d     = '0;
          state_d   = S_FLUSH;
        end
      end
      S_WAIT: begin
        if (core_out_valid) begin
          take    = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (core_out_valid) begin
          take = 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            take_last = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        // A full frame of discarded beats ends the flush early without error
        if (core_out_valid && cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (core_out_valid) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Input path: owner's samples go to the core only while loading
  always_comb begin
    in_load       = (state_q == S_LOAD);
    x_img_conj    = (s_img == 16'sh8000) ? 16'sh7FFF : -s_img;
    core_in_valid = in_load && s_valid;
    core_x_real   = in_load ? s_real : '0;
    core_x_img    = '0;
    if (in_load) begin
      core_x_img = inv_q ? x_img_conj : s_img;
    end
  end

  // Output path: conjugate and scale for INV frames, pass FWD frames through
  always_comb begin
    img_neg  = -{core_y_img[15], core_y_img};
    y_real_d = core_y_real;
    y_img_d  = core_y_img;
    if (inv_q) begin
      y_real_d = core_y_real >>> SCALE_SHIFT;
      y_img_d  = 16'(img_neg >>> SCALE_SHIFT);
    end
  end

  // State, counters and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      inv_q      <= 1'b0;
      pref_inv_q <= 1'b0;
      err_gap_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      y_real_q   <= '0;
      y_img_q    <= '0;
      y_is_inv_q <= 1'b0;
      y_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      inv_q      <= inv_d;
      pref_inv_q <= pref_inv_d;
      err_gap_q  <= err_gap_d;
      err_tmo_q  <= err_tmo_d;
      y_valid_q  <= take;
      y_real_q   <= take ? y_real_d : '0;
      y_img_q    <= take ? y_img_d : '0;
      y_is_inv_q <= take && inv_q;
      y_last_q   <= take_last;
    end
  end

  assign gnt_fwd     = (state_q == S_LOAD) && !inv_q;
  assign gnt_inv     = (state_q == S_LOAD) && inv_q;
  assign busy        = (state_q != S_IDLE);
  assign err_gap     = err_gap_q;
  assign err_timeout = err_tmo_q;
  assign y_valid     = y_valid_q;
  assign y_real      = y_real_q;
  assign y_img       = y_img_q;
  assign y_is_inv    = y_is_inv_q;
  assign y_last      = y_last_q;

endmodule

// File: tb/tb_fft256_share_sched.sv
// Directed bench for fft256_share_sched; the bench plays the FFT_256 core.
module tb_fft256_share_sched;

  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_fwd = 1'b0, req_inv = 1'b0;
  logic gnt_fwd, gnt_inv;
  logic s_valid = 1'b0;
  logic signed [15:0] s_real = '0, s_img = '0;
  logic core_in_valid;
  logic signed [15:0] core_x_real, core_x_img;
  logic core_out_valid = 1'b0;
  logic signed [15:0] core_y_real = '0, core_y_img = '0;
  logic y_valid, y_is_inv, y_last, busy, err_gap, err_timeout;
  logic signed [15:0] y_real, y_img;

  fft256_share_sched #(.N(256), .SCALE_SHIFT(8), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_fwd(req_fwd), .req_inv(req_inv),
    .gnt_fwd(gnt_fwd), .gnt_inv(gnt_inv),
    .s_valid(s_valid), .s_real(s_real), .s_img(s_img),
    .core_in_valid(core_in_valid), .core_x_real(core_x_real), .core_x_img(core_x_img),
    .core_out_valid(core_out_valid), .core_y_real(core_y_real), .core_y_img(core_y_img),
    .y_valid(y_valid), .y_real(y_real), .y_img(y_img),
    .y_is_inv(y_is_inv), .y_last(y_last), .busy(busy),
    .err_gap(err_gap), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int both_gnt = 0;

  always @(negedge clk) if (gnt_fwd && gnt_inv) both_gnt++;

  typedef struct {
    logic signed [15:0] sr, si, xr, xi;
  } in_vec_t;
  typedef struct {
    logic signed [15:0] cr, ci, yr, yi;
  } out_vec_t;

  in_vec_t  iv[5];
  out_vec_t ov[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {gnt_fwd, gnt_inv, core_in_valid, core_x_real, core_x_img, y_valid, y_real,
            y_img, y_is_inv, y_last, busy, err_gap, err_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream_zeros();
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1; s_real = '0; s_img = '0;
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Feed N zero beats from the core; count beats with unexpected outputs
  task automatic drain_zeros(input logic exp_inv, output int bad);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      core_out_valid = 1'b1; core_y_real = '0; core_y_img = '0;
      tick();
      if (y_valid !== 1'b1 || y_is_inv !== exp_inv || y_last !== (k == N - 1) ||
          gnt_fwd !== 1'b0 || gnt_inv !== 1'b0) bad++;
    end
    core_out_valid = 1'b0;
  endtask

  task automatic wait_gnt(output logic gf, output logic gi);
    for (int k = 0; k < 16; k++) begin
      if (gnt_fwd || gnt_inv) break;
      tick();
    end
    gf = gnt_fwd; gi = gnt_inv;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    logic gf, gi;

    iv[0] = '{16'sd100, 16'sd200, 16'sd100, -16'sd200};
    iv[1] = '{-16'sd5, 16'sh8000, -16'sd5, 16'sh7FFF};
    iv[2] = '{16'sd0, 16'sh7FFF, 16'sd0, 16'sh8001};
    iv[3] = '{16'sd7, -16'sd1, 16'sd7, 16'sd1};
    iv[4] = '{16'sh8000, 16'sd0, 16'sh8000, 16'sd0};
    ov[0] = '{16'sd256, 16'sd0, 16'sd1, 16'sd0};
    ov[1] = '{16'sh8000, 16'sh8000, -16'sd128, 16'sd128};
    ov[2] = '{16'sh7FFF, 16'sh7FFF, 16'sd127, -16'sd128};
    ov[3] = '{-16'sd1, 16'sd1, -16'sd1, -16'sd1};
    ov[4] = '{16'sd300, -16'sd300, 16'sd1, 16'sd1};
    ov[5] = '{-16'sd300, 16'sd0, -16'sd2, 16'sd0};

    // Reset state
    tick(); tick();
    check("reset_outputs", all_outs(), '0);

    // 1: FWD impulse frame
    rst_n = 1'b1; req_fwd = 1'b1;
    tick();
    check("t1_gnt", {gnt_fwd, gnt_inv, busy}, 3'b101);
    req_fwd = 1'b0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1; s_real = (i == 0) ? 16'sd1000 : 16'sd0; s_img = '0;
      #1;
      if (core_in_valid !== 1'b1 || core_x_real !== s_real || core_x_img !== 16'sd0 ||
          gnt_fwd !== 1'b1) bad++;
      tick();
    end
    s_valid = 1'b0;
    check("t1_in_path", bad, 0);
    check("t1_gnt_drop", {gnt_fwd, core_in_valid, core_x_real, busy}, {2'b00, 16'sd0, 1'b1});
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (k == 100) begin
        core_out_valid = 1'b0;
        tick();
        if (y_valid !== 1'b0 || y_real !== 16'sd0) bad++;
      end
      core_out_valid = 1'b1; core_y_real = 16'sd1000; core_y_img = '0;
      tick();
      if (y_valid !== 1'b1 || y_real !== 16'sd1000 || y_img !== 16'sd0 ||
          y_is_inv !== 1'b0 || y_last !== (k == N - 1)) bad++;
    end
    core_out_valid = 1'b0;
    check("t1_out_beats", bad, 0);
    check("t1_idle_after", busy, 1'b0);
    tick();
    check("t1_zero_when_idle", {y_valid, y_real, y_img, y_last}, '0);

    // 2/4: INV frame, conjugate + saturate input, conjugate + scale output
    req_inv = 1'b1;
    tick();
    check("t2_gnt", {gnt_fwd, gnt_inv}, 2'b01);
    req_inv = 1'b0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      if (i < 5) begin
        s_real = iv[i].sr; s_img = iv[i].si;
        #1;
        check($sformatf("t2_in%0d", i), {core_in_valid, core_x_real, core_x_img},
              {1'b1, iv[i].xr, iv[i].xi});
      end else begin
        s_real = 16'sd256; s_img = '0;
        #1;
        if (core_in_valid !== 1'b1 || core_x_real !== 16'sd256 || core_x_img !== 16'sd0) bad++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("t2_in_rest", bad, 0);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      core_out_valid = 1'b1;
      if (k < 6) begin
        core_y_real = ov[k].cr; core_y_img = ov[k].ci;
        tick();
        check($sformatf("t2_out%0d", k), {y_valid, y_real, y_img, y_is_inv, y_last},
              {1'b1, ov[k].yr, ov[k].yi, 2'b10});
      end else begin
        core_y_real = '0; core_y_img = '0;
        tick();
        if (y_valid !== 1'b1 || y_real !== 16'sd0 || y_img !== 16'sd0 ||
            y_is_inv !== 1'b1 || y_last !== (k == N - 1)) bad++;
      end
    end
    core_out_valid = 1'b0;
    check("t2_out_rest", bad, 0);
    check("t2_idle_after", busy, 1'b0);

    // 3: both requesting from reset -> FWD, INV, FWD
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    both_gnt = 0;
    req_fwd = 1'b1; req_inv = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_gnt(gf, gi);
      check($sformatf("t3_owner%0d", f), {gf, gi}, (f == 1) ? 2'b01 : 2'b10);
      if (f == 2) begin
        req_fwd = 1'b0; req_inv = 1'b0;
      end
      stream_zeros();
      drain_zeros(f == 1, bad);
      check($sformatf("t3_drain%0d", f), bad, 0);
    end
    check("t3_never_both", both_gnt, 0);

    // 5: gap at sample 100 of a FWD frame
    req_fwd = 1'b1;
    tick();
    req_fwd = 1'b0;
    check("t5_gnt", gnt_fwd, 1'b1);
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_real = 16'sd3; s_img = 16'sd4;
      tick();
    end
    s_valid = 1'b0;
    tick();
    check("t5_err_gap", {err_gap, busy, gnt_fwd}, 3'b110);
    tick();
    check("t5_err_gap_pulse", err_gap, 1'b0);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      core_out_valid = 1'b1; core_y_real = 16'sd500; core_y_img = 16'sd500;
      tick();
      if (y_valid !== 1'b0 || y_real !== 16'sd0) bad++;
    end
    core_out_valid = 1'b0;
    check("t5_flush_silent", bad, 0);
    check("t5_flush_exit", {busy, err_timeout}, 2'b00);

    // 6: core never answers -> timeout after 1024 WAIT cycles
    req_fwd = 1'b1;
    tick();
    req_fwd = 1'b0;
    stream_zeros();
    n = 0;
    while (err_timeout !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("t6_timeout_cycles", n, 1024);
    check("t6_busy_low", busy, 1'b0);
    tick();
    check("t6_timeout_pulse", err_timeout, 1'b0);

    // 6b: reset mid-DRAIN clears every output
    req_fwd = 1'b1;
    tick();
    req_fwd = 1'b0;
    stream_zeros();
    for (int k = 0; k < 10; k++) begin
      core_out_valid = 1'b1; core_y_real = 16'sd1000; core_y_img = -16'sd5;
      tick();
    end
    check("t6_pre_reset_busy", {busy, y_valid}, 2'b11);
    s_valid = 1'b1; s_real = 16'sd9; s_img = 16'sd9;
    rst_n = 1'b0;
    tick();
    check("t6_reset_outputs", all_outs(), '0);
    rst_n = 1'b1; s_valid = 1'b0; core_out_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
